// File: rtl/pbs_pkg.sv
// Shared types and constants for the AI move selector.
package pbs_pkg;

    typedef enum logic [1:0] {
        MOVE_ATK0 = 2'd0,
        MOVE_ATK1 = 2'd1,
        MOVE_ATK2 = 2'd2,
        MOVE_HEAL = 2'd3
    } move_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDraw   = 2'd1,
        StDecide = 2'd2,
        StHold   = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_SEED     = 16'hACE1;
    localparam logic [15:0] DEFAULT_TAP_MASK = 16'hB400;

    // Rotate through the three attacks: 0 -> 1 -> 2 -> 0.
    function automatic move_t next_attack(input move_t m);
        unique case (m)
            MOVE_ATK0: next_attack = MOVE_ATK1;
            MOVE_ATK1: next_attack = MOVE_ATK2;
            default:   next_attack = MOVE_ATK0;
        endcase
    endfunction

endpackage

// File: rtl/pbs_lfsr.sv
// Free-running Galois LFSR with synchronous seed load and an all-zero lock-up guard.
module pbs_lfsr #(
    parameter int unsigned         WIDTH    = 16,
    parameter logic [WIDTH-1:0]    SEED     = WIDTH'(16'hACE1),
    parameter logic [WIDTH-1:0]    TAP_MASK = WIDTH'(16'hB400)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = lfsr_q >> 1;
        lfsr_d  = lfsr_q[0] ? (shifted ^ TAP_MASK) : shifted;
        // Seed load wins over advance; a zero seed or zero state would lock up.
        if (seed_load) begin
            lfsr_d = (seed == '0) ? SEED : seed;
        end else if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/ai_move_sel.sv
// AI trainer move selector: LFSR draw, heal-priority rules, req/valid/ack result.
// Optional repeat filtering of attacks is enabled with `define AI_NO_REPEAT_EN.
module ai_move_sel
    import pbs_pkg::*;
#(
    parameter int unsigned          LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]    SEED      = LFSR_W'(DEFAULT_SEED),
    parameter logic [LFSR_W-1:0]    TAP_MASK  = LFSR_W'(DEFAULT_TAP_MASK),
    parameter logic [3:0]           LOW_HP    = 4'd3,
    parameter int unsigned          MAX_HEALS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              ack,
    input  logic [3:0]        ai_hp,
    input  logic              new_battle,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic [1:0]        ai_move,
    output logic [3:0]        accu_rng,
    output logic              valid,
    output logic              busy,
    output logic [1:0]        heals_left,
    output logic [LFSR_W-1:0] rng_state
);

    localparam logic [1:0] HEALS_INIT = 2'(MAX_HEALS);

    state_t      state_q, state_d;
    logic [7:0]  draw_q, draw_d;
    move_t       move_q, move_d;
    logic [3:0]  accu_q, accu_d;
    logic        valid_q, valid_d;
    logic [1:0]  heals_q, heals_d;

    move_t       dec_move;
    move_t       cand;
    logic        dec_use_heal;

`ifdef AI_NO_REPEAT_EN
    move_t       prev_q, prev_d;
    logic        dec_is_attack;
`endif

    logic [LFSR_W-1:0] lfsr;

    pbs_lfsr #(
        .WIDTH    (LFSR_W),
        .SEED     (SEED),
        .TAP_MASK (TAP_MASK)
    ) u_lfsr (
        .clk       (clk),
        .reset_n   (reset_n),
        .seed_load (seed_load),
        .seed      (seed),
        .state     (lfsr)
    );

    // Decision rules, evaluated against the latched draw and the live ai_hp.
    always_comb begin
        dec_move     = MOVE_ATK0;
        dec_use_heal = 1'b0;
        cand         = move_t'(draw_q[1:0]);
`ifdef AI_NO_REPEAT_EN
        dec_is_attack = 1'b0;
`endif
        if (ai_hp == 4'd0) begin
            // Dead AI: still finish the handshake, but spend nothing.
            dec_move = MOVE_ATK0;
        end else if ((ai_hp <= LOW_HP) && (heals_q != 2'd0)) begin
            dec_move     = MOVE_HEAL;
            dec_use_heal = 1'b1;
        end else begin
            if ((cand == MOVE_HEAL) && ((heals_q == 2'd0) || (ai_hp == 4'hF))) begin
                cand = move_t'({1'b0, draw_q[2]});
            end
            if (cand == MOVE_HEAL) begin
                dec_use_heal = 1'b1;
            end
`ifdef AI_NO_REPEAT_EN
            else begin
                if (cand == prev_q) begin
                    cand = next_attack(cand);
                end
                dec_is_attack = 1'b1;
            end
`endif
            dec_move = cand;
        end
    end

    always_comb begin
        state_d = state_q;
        draw_d  = draw_q;
        move_d  = move_q;
        accu_d  = accu_q;
        valid_d = valid_q;
        heals_d = heals_q;
`ifdef AI_NO_REPEAT_EN
        prev_d  = prev_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StDraw;
                end
            end
            StDraw: begin
                draw_d  = lfsr[7:0];
                state_d = StDecide;
            end
            StDecide: begin
                move_d  = dec_move;
                accu_d  = draw_q[7:4];
                valid_d = 1'b1;
                state_d = StHold;
                if (dec_use_heal) begin
                    heals_d = heals_q - 2'd1;
                end
`ifdef AI_NO_REPEAT_EN
                if (dec_is_attack) begin
                    prev_d = dec_move;
                end
`endif
            end
            StHold: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new battle aborts whatever is in flight and refills the heal budget.
        if (new_battle) begin
            state_d = StIdle;
            valid_d = 1'b0;
            heals_d = HEALS_INIT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            draw_q  <= '0;
            move_q  <= MOVE_ATK0;
            accu_q  <= '0;
            valid_q <= 1'b0;
            heals_q <= HEALS_INIT;
        end else begin
            state_q <= state_d;
            draw_q  <= draw_d;
            move_q  <= move_d;
            accu_q  <= accu_d;
            valid_q <= valid_d;
            heals_q <= heals_d;
        end
    end

`ifdef AI_NO_REPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= MOVE_ATK0;
        end else begin
            prev_q <= prev_d;
        end
    end
`endif

    assign ai_move    = move_q;
    assign accu_rng   = accu_q;
    assign valid      = valid_q;
    assign busy       = (state_q != StIdle);
    assign heals_left = heals_q;
    assign rng_state  = lfsr;

endmodule

// File: doc/ai_move_sel.md
Name: ai_move_sel

Overview:
Upstream stage for the battle datapath and control FSM. Chooses the AI trainer's move and produces the 4-bit accuracy roll (moveaccurng) that the datapath compares against move accuracy. A free-running Galois LFSR supplies the randomness. A small FSM applies the strategy rules (low-HP heal priority, heal budget) and presents the result through a req/valid/ack handshake.

Parameters:
LFSR_W, 16, LFSR width.
SEED, 16'hACE1, reset and zero-guard seed; must be nonzero.
TAP_MASK, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
LOW_HP, 4'd3, AI HP at or below this value forces a heal if budget remains.
MAX_HEALS, 2, heals per battle; width 2 bits.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
req  in  1  control FSM requests an AI decision; sampled only in IDLE.
ack  in  1  control FSM has consumed the result.
ai_hp  in  4  current AI HP from datapath (0..15).
new_battle  in  1  restores heal budget and aborts any decision in progress.
seed_load  in  1  load seed into LFSR.
seed  in  LFSR_W  seed value.
ai_move  out  2  0/1/2 = attack moves, 3 = heal.
accu_rng  out  4  accuracy roll, 0..15.
valid  out  1  ai_move/accu_rng are valid; held until ack.
busy  out  1  high in DRAW, DECIDE and HOLD.
heals_left  out  2  remaining heal budget.
rng_state  out  LFSR_W  current LFSR register (debug/verification).

Behaviour:
- Reset (async, reset_n low): lfsr=SEED, state IDLE, ai_move=0, accu_rng=0, valid=0, busy=0, heals_left=MAX_HEALS, prev_move=0.
- LFSR: advances every cycle regardless of state. Update: lfsr_next = lsb ? (lfsr>>1)^TAP_MASK : lfsr>>1.
  - seed_load has priority over advance: lfsr <= (seed==0) ? SEED : seed.
  - If lfsr ever reads 0, it reloads SEED on the next edge.
- FSM states: IDLE, DRAW, DECIDE, HOLD.
  - IDLE -> DRAW on req=1.
  - DRAW -> DECIDE unconditionally. Latch draw=lfsr at this edge.
  - DECIDE -> HOLD. Register ai_move and accu_rng=draw[7:4]; set valid=1.
  - HOLD -> IDLE on ack=1. Clear valid.
  - Latency: req edge k gives valid high after edge k+2.
  - ai_move and accu_rng keep their last values after ack.
- Decision rules, evaluated in DECIDE, using ai_hp as sampled at that edge:
  1. If ai_hp<=LOW_HP and heals_left>0: move=3, heals_left decrements.
  2. Otherwise cand=draw[1:0].
     - If cand==3 and (heals_left==0 or ai_hp==15): cand={1'b0,draw[2]}.
     - If cand==3 and the heal is allowed: heals_left decrements.
  3. If ai_hp==0 (AI dead): the decision still completes, with move=0. The control FSM ignores it.
- heals_left never underflows. It saturates at 0 because the rules above never choose a heal at 0.
- req outside IDLE is ignored. ack outside HOLD is ignored.
- new_battle takes effect at the next edge in any state: state IDLE, valid=0, heals_left=MAX_HEALS. The LFSR is untouched.
  - It beats a simultaneous req or ack.
  - It does not reset prev_move.
- Reset mid-operation: returns immediately to the reset values; the pending result is lost.

Optional Feature:
AI_NO_REPEAT_EN.
- Defined: in rule 2, if the final non-heal move equals prev_move, the move becomes (move+1) mod 3. Any attack chosen updates prev_move.
- Undefined: no repeat filtering; prev_move register absent.
- Rule 1 heals and randomly chosen heals are never filtered.

Decomposition:
- Package pbs_pkg:
  - move encodings MOVE_ATK0/1/2, MOVE_HEAL (2-bit typedef move_t);
  - the state enum typedef;
  - the default SEED and TAP_MASK constants.
- Sub-module pbs_lfsr (parameterised width/mask/seed; seed_load and zero guard) is natural. The FSM and rules stay in ai_move_sel.

Test Plan:
- Reset release -> rng_state=16'hACE1, then 16'hE270 after one edge; valid=0, heals_left=2.
- seed_load seed=16'h0001 -> rng_state=0001, next edge B400. seed_load seed=0 -> rng_state=ACE1.
- ai_hp=2, req pulse -> valid rises 2 edges later with ai_move=3, heals_left=1.
  - Repeat -> 3, heals_left=0.
  - Third req -> ai_move in {0,1,2}, heals_left=0.
- ai_hp=15, 200 requests with random seeds -> ai_move never 3.
  - accu_rng equals bits [7:4] of rng_state captured at the DRAW edge (scoreboard model).
- Assert valid, withhold ack 10 cycles; also pulse req during the wait -> valid and outputs stable, no new decision. Then ack -> valid=0 next edge, state IDLE.
- Assert new_battle in DECIDE with heals_left=0 -> valid stays 0, heals_left=2, busy=0. Assert reset_n low in HOLD -> all outputs at reset values asynchronously.
